// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types and constants for the 256x84 single-port SRAM controller.
// Sweep-related constants apply when CT_F_SPSRAM_INIT_EN is defined.
package ct_f_spsram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int HALF_WIDTH = 42;
    localparam int NUM_REQ    = 2;
    localparam int SWEEP_LAST = 255;

endpackage

// File: rtl/ct_f_spsram_rr_arb.sv
// Two-way round-robin arbiter; the pointer flips to the other requester after any grant.
module ct_f_spsram_rr_arb (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [1:0] vld,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant selection: a sole requester always wins, contention goes by pointer.
    always_comb begin
        gnt = 2'b00;
        case (vld)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ptr_r <= 1'b0;
        end else if (advance && gnt[0]) begin
            ptr_r <= 1'b1;
        end else if (advance && gnt[1]) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ct_f_spsram_256x84_ctrl.sv
// Two-requester controller for a 256x84 single-port SRAM with half-word write enables.
// Define CT_F_SPSRAM_INIT_EN to zero-fill the array after reset before accepting requests.
module ct_f_spsram_256x84_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 84
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [1:0]            req0_be,
    output logic                  req0_gnt,
    output logic                  rsp0_vld,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [1:0]            req1_be,
    output logic                  req1_gnt,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  init_done
);

`ifdef CT_F_SPSRAM_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 run_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [NUM_REQ-1:0]   rd_pend_r;
    logic                 sel_s;
    logic [1:0]           sel_be_s;

    assign run_s = (state_r == ST_RUN);

    ct_f_spsram_rr_arb u_arb (
        .clk     (forever_cpuclk),
        .rst_b   (cpurst_b),
        .vld     ({req1_vld, req0_vld} & {NUM_REQ{run_s}}),
        .advance (run_s),
        .gnt     (gnt_s)
    );

    assign req0_gnt = gnt_s[0];
    assign req1_gnt = gnt_s[1];
    assign sel_s    = gnt_s[1];
    assign sel_be_s = sel_s ? req1_be : req0_be;

`ifdef CT_F_SPSRAM_INIT_EN
    logic [ADDR_WIDTH-1:0] sweep_cnt_r;
    logic                  sweep_last_s;

    assign sweep_last_s = (sweep_cnt_r == ADDR_WIDTH'(SWEEP_LAST));

    // Sweep address counter, active only while initialising.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            sweep_cnt_r <= '0;
        end else if (state_r == ST_INIT) begin
            sweep_cnt_r <= sweep_cnt_r + 1'b1;
        end else begin
            sweep_cnt_r <= '0;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: INIT leaves once the last sweep address has been written.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
`ifdef CT_F_SPSRAM_INIT_EN
            ST_INIT: state_nxt_s = sweep_last_s ? ST_RUN : ST_INIT;
`else
            ST_INIT: state_nxt_s = ST_RUN;
`endif
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = RESET_STATE;
        endcase
    end

    // SRAM drive: sweep write, granted access, or parked idle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
`ifdef CT_F_SPSRAM_INIT_EN
        if (state_r == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = sweep_cnt_r;
        end else
`endif
        if (|gnt_s) begin
            sram_cen = 1'b0;
            sram_a   = sel_s ? req1_addr  : req0_addr;
            sram_d   = sel_s ? req1_wdata : req0_wdata;
            if (sel_s ? req1_wr : req0_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~{{(DATA_WIDTH-HALF_WIDTH){sel_be_s[1]}}, {HALF_WIDTH{sel_be_s[0]}}};
            end else begin
                sram_gwen = 1'b1;
                sram_wen  = '1;
            end
        end else begin
            sram_cen = 1'b1;
        end
    end

    // Read-pending flags: one cycle of SRAM read latency per requester.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_pend_r <= '0;
        end else begin
            rd_pend_r <= gnt_s & ~{req1_wr, req0_wr};
        end
    end

    // Responses are masked while reset is asserted so a dropped read never surfaces.
    assign rsp0_vld  = rd_pend_r[0] & cpurst_b;
    assign rsp1_vld  = rd_pend_r[1] & cpurst_b;
    assign rsp_rdata = (rsp0_vld | rsp1_vld) ? sram_q : '0;
    assign init_done = run_s;

endmodule
